// File: rtl/servo_arm_ctrl_n.sv
// Joystick-to-servo command engine: clamp/rescale, per-channel targets, centre button, ticked slew.
// Define SERVO_SLEW_EN to rate-limit commands by SLEW_US per tick; otherwise cmd jumps to target on tick.
module servo_arm_ctrl_n #(
  parameter int NUM_CH    = 4,
  parameter int JOY_W     = 10,
  parameter int US_W      = 12,
  parameter int RAW_MIN   = 228,
  parameter int RAW_MAX   = 830,
  parameter int US_MIN    = 650,
  parameter int US_MAX    = 2600,
  parameter int CENTER_US = 1500,
  parameter int SLEW_US   = 8,
  parameter int TICK_DIV  = 50000,
  parameter logic [7:0] AXIS_MAP = 8'b0000_1010
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [JOY_W-1:0]       x_pos,
  input  logic [JOY_W-1:0]       y_pos,
  input  logic                   sample_vld,
  input  logic                   center_btn,
  input  logic [NUM_CH-1:0]      sel,
  output logic [NUM_CH*US_W-1:0] cmd_us,
  output logic                   cmd_vld,
  output logic [NUM_CH-1:0]      settled
);

  localparam int     RAW_SPAN = RAW_MAX - RAW_MIN;
  localparam int     US_SPAN  = US_MAX - US_MIN;
  localparam longint K        = (longint'(US_SPAN) * 131072 + longint'(RAW_SPAN)) / (2 * longint'(RAW_SPAN));
  localparam int     CNT_W    = $clog2(TICK_DIV);
  localparam logic [US_W-1:0] CENTER = US_W'(CENTER_US);

  generate
    if (CENTER_US < US_MIN || CENTER_US > US_MAX) begin : g_bad_center
      $error("CENTER_US must lie within [US_MIN, US_MAX]");
    end
    if (SLEW_US < 1 || TICK_DIV < 2 || NUM_CH < 1 || NUM_CH > 8) begin : g_bad_param
      $error("SLEW_US >= 1, TICK_DIV >= 2 and NUM_CH in 1..8 are required");
    end
  endgenerate

  function automatic logic [JOY_W-1:0] clamp_off(input logic [JOY_W-1:0] raw);
    logic [JOY_W-1:0] c;
    c = raw;
    if (raw < JOY_W'(RAW_MIN)) c = JOY_W'(RAW_MIN);
    if (raw > JOY_W'(RAW_MAX)) c = JOY_W'(RAW_MAX);
    return c - JOY_W'(RAW_MIN);
  endfunction

  // Fixed-point rescale with round-half-up; final clamp guards against K rounding up past US_MAX.
  function automatic logic [US_W-1:0] map_us(input logic [JOY_W-1:0] d);
    logic [47:0] prod;
    logic [47:0] us;
    prod = 48'(d) * 48'(K) + 48'd32768;
    us   = 48'(US_MIN) + (prod >> 16);
    if (us > 48'(US_MAX)) us = 48'(US_MAX);
    return us[US_W-1:0];
  endfunction

  logic             s1_vld_q, s1_vld_d;
  logic [JOY_W-1:0] s1_x_q, s1_x_d, s1_y_q, s1_y_d;
  logic             btn_q, btn_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cmd_vld_q, cmd_vld_d;
  logic [US_W-1:0]  tgt_q [NUM_CH];
  logic [US_W-1:0]  tgt_d [NUM_CH];
  logic [US_W-1:0]  cmd_q [NUM_CH];
  logic [US_W-1:0]  cmd_d [NUM_CH];
  logic             tick, btn_rise;
  logic [US_W-1:0]  map_x, map_y;
`ifdef SERVO_SLEW_EN
  localparam logic signed [US_W:0] SLEW_S = (US_W+1)'(SLEW_US);
  logic signed [US_W:0] diff;
`endif

  always_comb begin
    s1_vld_d  = sample_vld;
    s1_x_d    = clamp_off(x_pos);
    s1_y_d    = clamp_off(y_pos);
    btn_d     = center_btn;
    btn_rise  = center_btn & ~btn_q;
    tick      = (cnt_q == CNT_W'(TICK_DIV - 1));
    cnt_d     = tick ? '0 : cnt_q + 1'b1;
    cmd_vld_d = tick;
    map_x     = map_us(s1_x_q);
    map_y     = map_us(s1_y_q);
`ifdef SERVO_SLEW_EN
    diff      = '0;
`endif
    for (int i = 0; i < NUM_CH; i++) begin
      tgt_d[i] = tgt_q[i];
      if (s1_vld_q && sel[i]) tgt_d[i] = AXIS_MAP[i] ? map_y : map_x;
      // Centre overrides a coincident sample on the same channel.
      if (btn_rise && sel[i]) tgt_d[i] = CENTER;
      cmd_d[i] = cmd_q[i];
      if (tick) begin
`ifdef SERVO_SLEW_EN
        diff = $signed({1'b0, tgt_q[i]}) - $signed({1'b0, cmd_q[i]});
        if (diff > SLEW_S)       cmd_d[i] = cmd_q[i] + US_W'(SLEW_US);
        else if (diff < -SLEW_S) cmd_d[i] = cmd_q[i] - US_W'(SLEW_US);
        else                     cmd_d[i] = tgt_q[i];
`else
        cmd_d[i] = tgt_q[i];
`endif
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_vld_q  <= 1'b0;
      s1_x_q    <= '0;
      s1_y_q    <= '0;
      btn_q     <= 1'b0;
      cnt_q     <= '0;
      cmd_vld_q <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        tgt_q[i] <= CENTER;
        cmd_q[i] <= CENTER;
      end
    end else begin
      s1_vld_q  <= s1_vld_d;
      s1_x_q    <= s1_x_d;
      s1_y_q    <= s1_y_d;
      btn_q     <= btn_d;
      cnt_q     <= cnt_d;
      cmd_vld_q <= cmd_vld_d;
      for (int i = 0; i < NUM_CH; i++) begin
        tgt_q[i] <= tgt_d[i];
        cmd_q[i] <= cmd_d[i];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign cmd_us[gi*US_W +: US_W] = cmd_q[gi];
      assign settled[gi]             = (cmd_q[gi] == tgt_q[gi]);
    end
  endgenerate

  assign cmd_vld = cmd_vld_q;

endmodule

// File: tb/tb_servo_arm_ctrl_n.sv
// Self-checking bench for servo_arm_ctrl_n with TICK_DIV=10; expectations follow SERVO_SLEW_EN.
module tb_servo_arm_ctrl_n;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [9:0]  x_pos = '0;
  logic [9:0]  y_pos = '0;
  logic        sample_vld = 1'b0;
  logic        center_btn = 1'b0;
  logic [3:0]  sel = '0;
  logic [47:0] cmd_us;
  logic        cmd_vld;
  logic [3:0]  settled;

  int n_cmp = 0;
  int n_bad = 0;

  servo_arm_ctrl_n #(.TICK_DIV(10)) dut (
    .CLK(CLK), .RST(RST), .x_pos(x_pos), .y_pos(y_pos), .sample_vld(sample_vld),
    .center_btn(center_btn), .sel(sel), .cmd_us(cmd_us), .cmd_vld(cmd_vld), .settled(settled)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [9:0]  x;
    logic [11:0] exp_tgt;
  } map_vec_t;

  map_vec_t    vecs [7];
  logic [11:0] exp_q [$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge CLK) RST = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK) RST = 1'b0;
  endtask

  // Strobe one sample; returns at the negedge before the edge that writes the targets.
  task automatic strobe(input logic [9:0] x, input logic [9:0] y);
    @(negedge CLK);
    x_pos = x; y_pos = y; sample_vld = 1'b1;
    @(negedge CLK);
    sample_vld = 1'b0;
  endtask

  task automatic wait_vld(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(posedge CLK); #1;
      if (cmd_vld) begin ok = 1'b1; return; end
    end
  endtask

  task automatic chk_tgts(input string nm, input logic [11:0] e0, input logic [11:0] e1,
                          input logic [11:0] e2, input logic [11:0] e3);
    chk({nm, "_t0"}, 64'(dut.tgt_q[0]), 64'(e0));
    chk({nm, "_t1"}, 64'(dut.tgt_q[1]), 64'(e1));
    chk({nm, "_t2"}, 64'(dut.tgt_q[2]), 64'(e2));
    chk({nm, "_t3"}, 64'(dut.tgt_q[3]), 64'(e3));
  endtask

  initial begin
    logic [11:0] exp_cmd;
    logic [11:0] popped;
    int          ticks;
    int          edges;
    bit          ok;
    bit          hit;

    vecs[0] = '{10'd228,  12'd650};
    vecs[1] = '{10'd529,  12'd1625};
    vecs[2] = '{10'd830,  12'd2600};
    vecs[3] = '{10'd100,  12'd650};
    vecs[4] = '{10'd1023, 12'd2600};
    vecs[5] = '{10'd229,  12'd653};
    vecs[6] = '{10'd400,  12'd1207};

    // Reset state and first cmd_vld timing
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_cmd_us", 64'(cmd_us), 64'({4{12'd1500}}));
    chk("rst_settled", 64'(settled), 64'hF);
    chk("rst_cmd_vld", 64'(cmd_vld), 64'd0);
    @(negedge CLK) RST = 1'b0;
    edges = 0;
    for (int e = 1; e <= 15; e++) begin
      @(posedge CLK); #1;
      edges = e;
      if (cmd_vld) break;
    end
    chk("first_vld_cycle", 64'(edges + 1), 64'd11);

    // Mapping table, back-to-back strobes, scoreboard on ch0 target
    do_reset();
    sel = 4'b0001;
    y_pos = 10'd500;
    for (int i = 0; i <= 7; i++) begin
      @(negedge CLK);
      if (i < 7) begin
        x_pos = vecs[i].x; sample_vld = 1'b1;
        exp_q.push_back(vecs[i].exp_tgt);
      end else begin
        sample_vld = 1'b0;
      end
      @(posedge CLK); #1;
      if (i >= 1) begin
        popped = exp_q.pop_front();
        $display("map x=%0d target0=%0d expected=%0d", vecs[i-1].x, dut.tgt_q[0], popped);
        chk("map_tgt0", 64'(dut.tgt_q[0]), 64'(popped));
      end
    end
    chk_tgts("map_other", dut.tgt_q[0], 12'd1500, 12'd1500, 12'd1500);

    // Ramp ch0 toward 2600
    do_reset();
    sel = 4'b0001;
    strobe(10'd830, 10'd0);
    exp_cmd = 12'd1500;
    ticks = 0;
    while (exp_cmd != 12'd2600 && ticks < 200) begin
      wait_vld(ok);
      if (!ok) begin
        chk("ramp_vld_timeout", 64'd0, 64'd1);
        break;
      end
      ticks++;
`ifdef SERVO_SLEW_EN
      exp_cmd = (12'd2600 - exp_cmd <= 12'd8) ? 12'd2600 : exp_cmd + 12'd8;
`else
      exp_cmd = 12'd2600;
`endif
      chk("ramp_cmd0", 64'(cmd_us[11:0]), 64'(exp_cmd));
      chk("ramp_settled0", 64'(settled[0]), 64'(exp_cmd == 12'd2600));
    end
    $display("ramp ticks=%0d cmd0=%0d", ticks, cmd_us[11:0]);
`ifdef SERVO_SLEW_EN
    chk("ramp_ticks", 64'(ticks), 64'd138);
`else
    chk("ramp_ticks", 64'(ticks), 64'd1);
`endif
    chk("ramp_others", 64'(cmd_us[47:12]), 64'({3{12'd1500}}));

    // All channels, axis map, held centre button
    do_reset();
    sel = 4'b1111;
    strobe(10'd228, 10'd830);
    @(posedge CLK); #1;
    chk_tgts("axis", 12'd650, 12'd2600, 12'd650, 12'd2600);
    @(negedge CLK) center_btn = 1'b1;
    @(posedge CLK); #1;
    chk_tgts("centre", 12'd1500, 12'd1500, 12'd1500, 12'd1500);
    repeat (10) @(negedge CLK);
    strobe(10'd228, 10'd830);
    @(posedge CLK); #1;
    chk_tgts("held_strobe", 12'd650, 12'd2600, 12'd650, 12'd2600);
    repeat (35) @(posedge CLK);
    #1;
    chk_tgts("held_no_refire", 12'd650, 12'd2600, 12'd650, 12'd2600);
    @(negedge CLK) center_btn = 1'b0;
    repeat (3) @(negedge CLK);

    // Centre edge coincident with mapped-valid
    strobe(10'd830, 10'd228);
    @(posedge CLK); #1;
    chk_tgts("pre_coinc", 12'd2600, 12'd650, 12'd2600, 12'd650);
    @(negedge CLK);
    x_pos = 10'd400; y_pos = 10'd400; sample_vld = 1'b1; sel = 4'b0011;
    @(negedge CLK);
    sample_vld = 1'b0; center_btn = 1'b1;
    @(posedge CLK); #1;
    chk_tgts("coinc", 12'd1500, 12'd1500, 12'd2600, 12'd650);
    @(negedge CLK) center_btn = 1'b0;

    // Reset mid-ramp
    do_reset();
    sel = 4'b0001;
    strobe(10'd830, 10'd0);
    hit = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      @(posedge CLK); #1;
      if (cmd_us[11:0] >= 12'd2000) begin hit = 1'b1; break; end
    end
    chk("midramp_reached", 64'(hit), 64'd1);
    @(negedge CLK) RST = 1'b1;
    @(posedge CLK); #1;
    chk("midrst_cmd0", 64'(cmd_us[11:0]), 64'd1500);
    chk("midrst_tgt0", 64'(dut.tgt_q[0]), 64'd1500);
    chk("midrst_settled", 64'(settled), 64'hF);
    chk("midrst_cnt", 64'(dut.cnt_q), 64'd0);
    chk("midrst_vld", 64'(cmd_vld), 64'd0);
    @(negedge CLK) RST = 1'b0;
    repeat (2) @(posedge CLK);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
